// File: rtl/pll_reset_supervisor.sv
// PLL reset/lock supervisor on the PLL reference clock.
// Pulses the PLL reset, waits for lock, and checks that lock holds for a
// programmed time before it releases the system reset. It re-runs the
// sequence on lock timeout, on lock loss in RUN, or on a software request.
module pll_reset_supervisor #(
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT  = 1000000
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       locked_sync,
  output logic [1:0] state,
  output logic [7:0] lock_loss_cnt,
  output logic [7:0] timeout_cnt
);

  localparam logic [1:0] ST_RESET_PLL   = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK   = 2'd1;
  localparam logic [1:0] ST_STABLE_WAIT = 2'd2;
  localparam logic [1:0] ST_RUN         = 2'd3;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned MAX_RS  = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int unsigned TMR_MAX = (MAX_RS > LOCK_TIMEOUT) ? MAX_RS : LOCK_TIMEOUT;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;

  // Synchroniser input stages for the asynchronous lock indicator.
  always_comb begin
    sync1_d = pll_locked;
    sync2_d = sync1_q;
  end

  // Next-state and registered-output logic.
  // A forced relock overrides all other transitions. Timers clear on every state change.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    loss_d  = loss_q;
    tmo_d   = tmo_q;

    case (state_q)
      ST_RESET_PLL: begin
        if (tmr_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (sync2_q) begin
          state_d = ST_STABLE_WAIT;
          tmr_d   = '0;
        end else if (tmr_q == TMO_LAST) begin
          state_d = ST_RESET_PLL;
          tmr_d   = '0;
          tmo_d   = (tmo_q == CNT_SAT) ? tmo_q : tmo_q + CNT_W'(1);
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_STABLE_WAIT: begin
        if (!sync2_q) begin
          state_d = ST_WAIT_LOCK;
          tmr_d   = '0;
        end else if (tmr_q == STABLE_LAST) begin
          state_d = ST_RUN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_RUN: begin
        tmr_d = '0;
        if (!sync2_q) begin
          state_d = ST_RESET_PLL;
          loss_d  = (loss_q == CNT_SAT) ? loss_q : loss_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RESET_PLL;
        tmr_d   = '0;
      end
    endcase

    if (force_relock) begin
      state_d = ST_RESET_PLL;
      tmr_d   = '0;
      loss_d  = loss_q;
      tmo_d   = tmo_q;
    end

    // Outputs follow the state being entered, so they change on the transition edge.
    pll_rst_d   = (state_d == ST_RESET_PLL);
    sys_rst_n_d = (state_d == ST_RUN);
  end

  // State, timer, counter and output registers. Reset holds the PLL in reset.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= ST_RESET_PLL;
      tmr_q       <= '0;
      loss_q      <= '0;
      tmo_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      loss_q      <= loss_d;
      tmo_q       <= tmo_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign locked_sync   = sync2_q;
  assign state         = state_q;
  assign lock_loss_cnt = loss_q;
  assign timeout_cnt   = tmo_q;

endmodule

// File: tb/tb_pll_reset_supervisor.sv
// Directed bench for pll_reset_supervisor with short timing parameters.
module tb_pll_reset_supervisor;

  logic       refclk       = 1'b0;
  logic       rst_n        = 1'b0;
  logic       pll_locked   = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       locked_sync;
  logic [1:0] state;
  logic [7:0] lock_loss_cnt;
  logic [7:0] timeout_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pll_reset_supervisor #(
    .RST_CYCLES   (4),
    .STABLE_CYCLES(16),
    .LOCK_TIMEOUT (100)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .force_relock (force_relock),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .locked_sync  (locked_sync),
    .state        (state),
    .lock_loss_cnt(lock_loss_cnt),
    .timeout_cnt  (timeout_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
    int k = 0;
    while (state !== s && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  // Counts edges until sys_rst_n rises, and pll_rst-high samples on the way.
  task automatic count_to_run(input int budget, output int n, output int w);
    n = 0;
    w = 0;
    while (sys_rst_n !== 1'b1 && n < budget) begin
      tick();
      n++;
      if (pll_rst) w++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_pll_rst"}, 32'(pll_rst), 1);
    check({tag, "_sys_rst_n"}, 32'(sys_rst_n), 0);
    check({tag, "_locked_sync"}, 32'(locked_sync), 0);
    check({tag, "_loss"}, 32'(lock_loss_cnt), 0);
    check({tag, "_tmo"}, 32'(timeout_cnt), 0);
  endtask

  initial begin
    int hi, n, w, w2, k, prev, sys_hi;
    int rise_at[$];
    int widths[$];

    // 1: power-up sequence with lock arriving 10 cycles after release
    repeat (3) tick();
    check_reset_outputs("t1_rst");
    rst_n = 1'b1;
    hi = pll_rst ? 1 : 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (pll_rst) hi++;
      if (i == 4) check("t1_state_wait", 32'(state), 1);
    end
    check("t1_pll_rst_width", 32'(hi), 4);
    pll_locked = 1'b1;
    count_to_run(100, n, w);
    check("t1_lock_to_run", 32'(n), 19);
    check("t1_state_run", 32'(state), 3);
    check("t1_pll_rst_off", 32'(pll_rst), 0);
    check("t1_locked_sync", 32'(locked_sync), 1);

    // 2: no lock for 350 cycles gives three timeouts
    pll_locked = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t2_async_rst");
    tick();
    tick();
    rst_n = 1'b1;
    prev = 1;
    w = 0;
    sys_hi = 0;
    for (int t = 1; t <= 350; t++) begin
      tick();
      if (pll_rst && prev == 0) begin
        rise_at.push_back(t);
        w = 0;
      end
      if (pll_rst) w++;
      if (!pll_rst && prev == 1 && rise_at.size() > 0) widths.push_back(w);
      if (sys_rst_n) sys_hi++;
      prev = pll_rst ? 1 : 0;
    end
    check("t2_timeout_cnt", 32'(timeout_cnt), 3);
    check("t2_rise_count", 32'(rise_at.size()), 3);
    check("t2_width_count", 32'(widths.size()), 3);
    if (rise_at.size() >= 2) begin
      check("t2_first_rise", 32'(rise_at[0]), 104);
      check("t2_spacing", 32'(rise_at[1] - rise_at[0]), 104);
    end
    foreach (widths[i]) check("t2_pulse_width", 32'(widths[i]), 4);
    check("t2_sys_hi", 32'(sys_hi), 0);
    check("t2_loss", 32'(lock_loss_cnt), 0);

    // 3: lock loss in RUN for 5 cycles, then restore
    pll_locked = 1'b1;
    wait_state(2'd3, 200, "t3_reach_run");
    pll_locked = 1'b0;
    n = 0;
    while (sys_rst_n === 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("t3_loss_latency", 32'(n), 3);
    check("t3_pll_rst_on", 32'(pll_rst), 1);
    check("t3_state_reset", 32'(state), 0);
    check("t3_loss_cnt", 32'(lock_loss_cnt), 1);
    w = 1;
    tick();
    if (pll_rst) w++;
    tick();
    if (pll_rst) w++;
    pll_locked = 1'b1;
    count_to_run(100, n, w2);
    check("t3_restore_to_run", 32'(n), 19);
    check("t3_pll_rst_width", 32'(w + w2), 4);
    check("t3_tmo_cnt", 32'(timeout_cnt), 3);

    // 4: two-cycle glitch at stable count 10
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    wait_state(2'd2, 50, "t4_reach_stable");
    repeat (10) tick();
    check("t4_still_stable", 32'(state), 2);
    pll_locked = 1'b0;
    tick();
    tick();
    pll_locked = 1'b1;
    tick();
    check("t4_back_wait", 32'(state), 1);
    check("t4_sys_off", 32'(sys_rst_n), 0);
    count_to_run(100, n, w);
    check("t4_restore_to_run", 32'(n + 1), 19);
    check("t4_loss_cnt", 32'(lock_loss_cnt), 1);
    check("t4_tmo_cnt", 32'(timeout_cnt), 3);

    // 5: force_relock in RUN, then again on the second RESET_PLL cycle
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    check("t5_sys_off", 32'(sys_rst_n), 0);
    check("t5_state_reset", 32'(state), 0);
    w = pll_rst ? 1 : 0;
    tick();
    if (pll_rst) w++;
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    if (pll_rst) w++;
    k = 0;
    while (pll_rst && k < 20) begin
      tick();
      k++;
      if (pll_rst) w++;
    end
    check("t5_pll_rst_width", 32'(w), 6);
    check("t5_loss_cnt", 32'(lock_loss_cnt), 1);
    check("t5_tmo_cnt", 32'(timeout_cnt), 3);
    wait_state(2'd3, 50, "t5_rerun");

    // 6: 300 lock losses saturate the counter, then reset mid-STABLE_WAIT
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      wait_state(2'd0, 10, "t6_loss");
      pll_locked = 1'b1;
      wait_state(2'd3, 50, "t6_rerun");
      if (i == 252) check("t6_loss_254", 32'(lock_loss_cnt), 254);
    end
    check("t6_loss_sat", 32'(lock_loss_cnt), 255);
    check("t6_tmo_cnt", 32'(timeout_cnt), 3);
    pll_locked = 1'b0;
    wait_state(2'd0, 10, "t6_last_loss");
    pll_locked = 1'b1;
    wait_state(2'd2, 20, "t6_stable");
    repeat (5) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async_rst");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t6_restart_rst_on", 32'(pll_rst), 1);
    check("t6_restart_state0", 32'(state), 0);
    tick();
    check("t6_restart_rst_off", 32'(pll_rst), 0);
    check("t6_restart_state1", 32'(state), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
